regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the pipeline CPU datapath. It replaces the fixed 32x32, 2-read, 1-write register file.
- Clock: rising edge.
- Reset: synchronous.
- Clearing: a sequential scrub engine zeroes the array one entry per cycle, so the array can map to RAM.
- Writes: per-byte enables.
- Entry 0: optional hardwired zero.
- Forwarding: optional same-cycle write-to-read.

Parameters:
DATA_W, 32, entry width in bits; must be a multiple of 8.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
NUM_RD, 2, number of read ports, range 1..4.
ZERO_REG0, 1, 1 = entry 0 always reads 0 and ignores writes.

Ports:
clk  in  1  clock, rising edge active
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit b covers bits [8b+7:8b]
init_busy  out  1  high while the array is being scrubbed
wr_drop  out  1  pulse: a write was discarded because init_busy was high

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port name reset. All state updates on the rising edge of clk.
- FSM states: CLEAR, READY.
- Registers: clr_ptr (ADDR_W bits), init_busy, wr_drop.
- While reset=1 at an edge:
  - state<=CLEAR, clr_ptr<=0, init_busy<=1, wr_drop<=0.
  - Array contents are not written.
- CLEAR, reset=0, each edge:
  - mem[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1: state<=READY, init_busy<=0.
  - init_busy is therefore high for exactly DEPTH edges after the first edge with reset=0.
- Reset asserted mid-scrub: scrub restarts from entry 0. No partial-scrub state survives.
- Writes in CLEAR: wr_en=1 is discarded. wr_drop<=1 for one cycle, otherwise wr_drop<=0.
- READY write rule, at the edge when wr_en=1:
  - Applies only if (wr_addr!=0 || ZERO_REG0==0).
  - For each b with wr_be[b]=1: mem[wr_addr][8b+7:8b]<=wr_data[8b+7:8b].
  - Bytes with wr_be[b]=0 keep their value.
  - wr_be=0 is a legal no-op.
- Reads are combinational from rd_addr, with zero latency.
  - Port k returns 0 if init_busy=1.
  - Port k returns 0 if ZERO_REG0=1 and rd_addr[k]==0.
  - Otherwise port k returns mem[rd_addr[k]], i.e. the value before any write at the current edge, unless forwarding is enabled.
- Multiple read ports on the same address return identical data. There is no port conflict.
- Output reset values: init_busy=1, wr_drop=0, rd_data=0 (all ports, forced while busy).
- Only one write port exists, so there are no write-write collisions.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined, when state=READY, wr_en=1, and rd_addr[k]==wr_addr with the write legal:
  - Port k returns the merged value combinationally, in the same cycle.
  - Merged value: enabled bytes from wr_data, other bytes from mem.
  - Zero-register and busy masking still take priority.
- Not defined: read ports never see same-cycle write data. The new value is visible from the cycle after the edge.

Test Plan:
- Scrub timing: reset=1 for 3 cycles, then 0; DEPTH=32 -> init_busy high for exactly 32 edges after deassert. Then every address reads 0 on all ports.
- Byte-enable writes:
  - Write addr 5, data 0xAABBCCDD, wr_be=4'b1111, then data 0x11223344 with wr_be=4'b0101.
  - Next cycle rd_addr[0]=5 -> 0xAA22CC44.
- Zero register:
  - ZERO_REG0=1: write 0xFFFFFFFF to addr 0 -> all ports read 0.
  - ZERO_REG0=0: same write -> reads 0xFFFFFFFF.
- Write during scrub: wr_en=1, addr 3, data 0x12345678, 2 cycles after reset deassert -> wr_drop pulses 1 cycle; addr 3 reads 0 after scrub.
- Reset mid-scrub: assert reset at scrub cycle 10 for 1 cycle, then deassert -> init_busy high for a full 32 further edges.
- Bypass:
  - Write addr 7, data 0x0000BEEF, all bytes; rd_addr[1]=7 in the same cycle.
  - REGFILE_BYPASS_EN defined -> rd_data port 1 = 0x0000BEEF in that cycle.
  - Not defined -> old value in that cycle, 0x0000BEEF from the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD combinational read
// ports and one byte-enabled write port. Before use, a scrub engine clears
// the array one entry per cycle, so the storage can map onto RAM.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to matching
// read ports.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    output logic                     init_busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NBYTE = DATA_W / 8;

    typedef enum logic [0:0] {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
    logic                busy_nxt;
    logic                drop_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_legal;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NBYTE-1:0]    mem_wbe;

    // Entry 0 is write-protected when it is hardwired to zero.
    assign wr_legal = wr_en && ((wr_addr != '0) || (ZERO_REG0 == 0));

    // Control state register; reset restarts the scrub from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
            wr_drop   <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_ptr   <= clr_ptr_nxt;
            init_busy <= busy_nxt;
            wr_drop   <= drop_nxt;
        end
    end

    // Next-state logic: walk the scrub pointer, drop writes while busy.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        busy_nxt    = 1'b0;
        drop_nxt    = 1'b0;
        case (state)
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + 1'b1;
                busy_nxt    = 1'b1;
                drop_nxt    = wr_en;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = READY;
                    busy_nxt  = 1'b0;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = CLEAR;
                busy_nxt  = 1'b1;
            end
        endcase
    end

    // Single array write port shared by the scrub engine and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wbe   = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wbe   = '1;
            end else if (wr_legal) begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr;
                mem_wdata = wr_data;
                mem_wbe   = wr_be;
            end
        end
    end

    // Byte-masked array update; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (mem_wbe[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] merged;

    // Value the write target will hold after this edge.
    always_comb begin
        merged = mem[wr_addr];
        for (int b = 0; b < NBYTE; b++) begin
            if (wr_be[b]) begin
                merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Combinational read; busy and zero-register masking win over forwarding.
        always_comb begin
            rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if ((state == READY) && wr_legal && (ra == wr_addr)) begin
                rv = merged;
            end
`endif
            if (init_busy || ((ZERO_REG0 != 0) && (ra == '0))) begin
                rv = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (entry 0 hardwired / not) share one
// stimulus stream and are compared every cycle against an array model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data_z, rd_data_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [DW/8-1:0]  wr_be;
    logic             busy_z, busy_n, drop_z, drop_n;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG0(1)) dut_z (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .init_busy(busy_z), .wr_drop(drop_z)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG0(0)) dut_n (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .init_busy(busy_n), .wr_drop(drop_n)
    );

    // ---------------- behavioural model ----------------
    bit          m_busy;
    int          m_cnt;
    bit          m_drop;
    logic [31:0] mz [DEPTH];
    logic [31:0] mn [DEPTH];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Scrub is a countdown of DEPTH edges ending in an all-zero array;
    // writes are dropped meanwhile, so clearing everything at the end is equivalent.
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_drop = 1'b0;
        end else if (m_busy) begin
            m_drop = wr_en;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_busy = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    mz[i] = '0;
                    mn[i] = '0;
                end
            end
        end else begin
            m_drop = 1'b0;
            if (wr_en) begin
                mn[wr_addr] = merge(mn[wr_addr], wr_data, wr_be);
                if (wr_addr != 0) mz[wr_addr] = merge(mz[wr_addr], wr_data, wr_be);
            end
        end
    end

    function automatic logic [31:0] exp_rd(input bit zero, input logic [AW-1:0] a);
        logic [31:0] v;
        if (m_busy) return '0;
        if (zero && a == 0) return '0;
        v = zero ? mz[a] : mn[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == wr_addr && !(zero && wr_addr == 0)) v = merge(v, wr_data, wr_be);
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_z", 32'(busy_z), 32'(m_busy));
            check("busy_n", 32'(busy_n), 32'(m_busy));
            check("drop_z", 32'(drop_z), 32'(m_drop));
            check("drop_n", 32'(drop_n), 32'(m_drop));
            for (int k = 0; k < NR; k++) begin
                check($sformatf("rd_z[%0d]", k), rd_data_z[k*DW +: DW],
                      exp_rd(1'b1, rd_addr[k*AW +: AW]));
                check($sformatf("rd_n[%0d]", k), rd_data_n[k*DW +: DW],
                      exp_rd(1'b0, rd_addr[k*AW +: AW]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr[0 +: AW]  = a0;
        rd_addr[AW +: AW] = a1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy_z && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'd32);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_addr = '0;
        tick();
        chk_en = 1'b1;
        check("reset_busy", 32'(busy_z), 32'd1);
        check("reset_drop", 32'(drop_z), 32'd0);
        check("reset_rd", rd_data_z[31:0], 32'd0);
        tick(); tick();
        reset = 1'b0;
        count_busy("scrub_len");

        // Full sweep: everything reads zero after scrub.
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(AW'(a), AW'(DEPTH - 1 - a));
            #1;
            if (rd_data_z !== '0 || rd_data_n !== '0) check("sweep_zero", 32'hDEAD, 32'd0);
            else check("sweep_zero", 32'd0, 32'd0 + 32'(rd_data_z[0]));
            tick();
        end

        // Byte-enable merge.
        wr(5'd5, 32'hAABBCCDD, 4'b1111);
        wr(5'd5, 32'h11223344, 4'b0101);
        set_rd(5'd5, 5'd5);
        #1;
        check("be_merge_p0", rd_data_z[31:0], 32'hAA22CC44);
        check("be_merge_p1", rd_data_n[63:32], 32'hAA22CC44);
        check("be_model", mz[5], 32'hAA22CC44);
        wr(5'd5, 32'h00000000, 4'b0000);
        #1;
        check("be_zero_noop", rd_data_z[31:0], 32'hAA22CC44);

        // Zero register.
        wr(5'd0, 32'hFFFFFFFF, 4'b1111);
        set_rd(5'd0, 5'd0);
        #1;
        check("zero_z_p0", rd_data_z[31:0], 32'h0);
        check("zero_z_p1", rd_data_z[63:32], 32'h0);
        check("zero_n_p0", rd_data_n[31:0], 32'hFFFFFFFF);
        check("zero_n_p1", rd_data_n[63:32], 32'hFFFFFFFF);

        // A few more patterns across different addresses and ports.
        wr(5'd31, 32'h0F0F0F0F, 4'b1111);
        wr(5'd1,  32'hCAFEF00D, 4'b1010);
        wr(5'd31, 32'hF0000000, 4'b1000);
        set_rd(5'd31, 5'd1);
        tick();
        #1;
        check("hi_addr", rd_data_z[31:0], 32'hF00F0F0F);
        check("be_1010", rd_data_z[63:32], 32'hCA00F000);

        // Same-cycle forwarding.
        set_rd(5'd5, 5'd7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000BEEF; wr_be = 4'b1111;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same", rd_data_z[63:32], 32'h0000BEEF);
`else
        check("bypass_same", rd_data_z[63:32], 32'h00000000);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        check("bypass_next", rd_data_z[63:32], 32'h0000BEEF);
        tick();

        // Write during scrub is dropped.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; wr_be = 4'b1111;
        tick();
        wr_en = 1'b0;
        #1;
        check("drop_pulse", 32'(drop_z), 32'd1);
        tick();
        check("drop_clear", 32'(drop_z), 32'd0);
        while (busy_z) tick();
        set_rd(5'd3, 5'd7);
        #1;
        check("drop_addr3", rd_data_n[31:0], 32'h0);
        check("rescrub_addr7", rd_data_n[63:32], 32'h0);

        // Reset mid-scrub restarts the full count.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy("midscrub_len");
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
